// File: rtl/his_peak_finder_pkg.sv
// Shared types and defaults for the histogram peak finder: FSM encoding,
// parameter defaults and a constant clog2 helper.
package his_peak_finder_pkg;

   localparam int BIN_NUM_PER_HIS_D   = 16;
   localparam int PIXEL_NUM_PER_RAM_D = 4;
   localparam int RAM_ADDR_D          = 6;
   localparam int PEAK_MAX_D          = 8;

   function automatic int his_clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   localparam int NB_D = his_clog2(BIN_NUM_PER_HIS_D);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SCAN  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_OUT   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/his_peak_finder_cmp.sv
// peak_cmp_reg: running max/argmax register. The first valid sample loads
// unconditionally; later samples replace only on a strictly larger count.
module peak_cmp_reg
   import his_peak_finder_pkg::*;
#(
   parameter int PEAK_MAX = PEAK_MAX_D,
   parameter int NB       = NB_D
) (
   input  logic                i_clk,
   input  logic                i_res,
   input  logic                i_first,
   input  logic                i_valid,
   input  logic [PEAK_MAX-1:0] i_counts,
   input  logic [NB-1:0]       i_bin_idx,
   output logic [PEAK_MAX-1:0] o_max_count,
   output logic [NB-1:0]       o_max_bin
);

   logic [PEAK_MAX-1:0] r_max_count;
   logic [NB-1:0]       r_max_bin;

   // Strict compare keeps the lower bin index on ties.
   always_ff @(posedge i_clk or posedge i_res) begin
      if (i_res) begin
         r_max_count <= '0;
         r_max_bin   <= '0;
      end else if (i_valid && (i_first || (i_counts > r_max_count))) begin
         r_max_count <= i_counts;
         r_max_bin   <= i_bin_idx;
      end
   end

   assign o_max_count = r_max_count;
   assign o_max_bin   = r_max_bin;

endmodule

// File: rtl/his_peak_finder.sv
// Scans each pixel histogram over RAM port b and streams one peak per pixel.
// Build option CLEAR_AFTER_READ_EN zeroes every bin through port a after it is read.
module his_peak_finder
   import his_peak_finder_pkg::*;
#(
   parameter int BIN_NUM_PER_HIS   = BIN_NUM_PER_HIS_D,
   parameter int PIXEL_NUM_PER_RAM = PIXEL_NUM_PER_RAM_D,
   parameter int RAM_ADDR          = RAM_ADDR_D,
   parameter int NB                = NB_D,
   parameter int PEAK_MAX          = PEAK_MAX_D,
   localparam int PW = (his_clog2(PIXEL_NUM_PER_RAM) > 0) ? his_clog2(PIXEL_NUM_PER_RAM) : 1
) (
   input  logic                i_clk,
   input  logic                i_res,
   input  logic                i_start,
   input  logic [PEAK_MAX-1:0] i_counts,
   output logic [RAM_ADDR-1:0] o_raddr,
   output logic                o_r_enable,
   output logic                o_read_flag,
   output logic [RAM_ADDR-1:0] o_waddr,
   output logic                o_w_enable,
   output logic                o_write_flag,
   output logic [PEAK_MAX-1:0] o_new_counts,
   output logic                o_peak_valid,
   input  logic                i_peak_ready,
   output logic [PW-1:0]       o_peak_pixel,
   output logic [NB-1:0]       o_peak_bin,
   output logic [PEAK_MAX-1:0] o_peak_count,
   output logic                o_busy,
   output logic                o_find_done,
   output state_t              o_dbg_state
);

   // Result handshake: a transfer happens on every rising edge where
   // o_peak_valid && i_peak_ready; the result is held stable until then.

   localparam int LAST_BIN = BIN_NUM_PER_HIS - 1;
   localparam int LAST_PIX = PIXEL_NUM_PER_RAM - 1;

   state_t              r_state;
   logic [PW-1:0]       r_pixel;
   logic [NB-1:0]       r_bin;
   logic [RAM_ADDR-1:0] r_raddr;
   logic                r_ren;
   logic                r_rd_valid;
   logic [NB-1:0]       r_rd_bin;
   logic                r_peak_valid;
   logic                r_find_done;
   logic                w_handshake;
   logic                w_first;

   function automatic logic [RAM_ADDR-1:0] addr_of(input logic [PW-1:0] pixel,
                                                   input logic [NB-1:0] bin);
      return RAM_ADDR'(pixel) * RAM_ADDR'(BIN_NUM_PER_HIS) + RAM_ADDR'(bin);
   endfunction

   assign w_handshake = r_peak_valid && i_peak_ready;

   always_ff @(posedge i_clk or posedge i_res) begin
      if (i_res) begin
         r_state      <= ST_IDLE;
         r_pixel      <= '0;
         r_bin        <= '0;
         r_raddr      <= '0;
         r_ren        <= 1'b0;
         r_peak_valid <= 1'b0;
         r_find_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state <= ST_SCAN;
                  r_pixel <= '0;
                  r_bin   <= '0;
                  r_raddr <= '0;
                  r_ren   <= 1'b1;
               end
            end
            ST_SCAN: begin
               if (r_bin == NB'(LAST_BIN)) begin
                  r_state <= ST_DRAIN;
                  r_ren   <= 1'b0;
               end else begin
                  r_bin   <= r_bin + 1'b1;
                  r_raddr <= addr_of(r_pixel, r_bin + 1'b1);
               end
            end
            ST_DRAIN: begin
               // Last bin's data is compared this cycle; result is final next cycle.
               r_state      <= ST_OUT;
               r_peak_valid <= 1'b1;
            end
            ST_OUT: begin
               if (w_handshake) begin
                  r_peak_valid <= 1'b0;
                  if (r_pixel == PW'(LAST_PIX)) begin
                     r_state     <= ST_DONE;
                     r_find_done <= 1'b1;
                  end else begin
                     r_state <= ST_SCAN;
                     r_pixel <= r_pixel + 1'b1;
                     r_bin   <= '0;
                     r_raddr <= addr_of(r_pixel + 1'b1, '0);
                     r_ren   <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               r_find_done <= 1'b0;
               r_state     <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // RAM data arrives one cycle after the read; track which bin it belongs to.
   always_ff @(posedge i_clk or posedge i_res) begin
      if (i_res) begin
         r_rd_valid <= 1'b0;
         r_rd_bin   <= '0;
      end else begin
         r_rd_valid <= r_ren;
         r_rd_bin   <= r_bin;
      end
   end

   assign w_first = (r_rd_bin == '0);

   peak_cmp_reg #(
      .PEAK_MAX (PEAK_MAX),
      .NB       (NB)
   ) u_cmp (
      .i_clk       (i_clk),
      .i_res       (i_res),
      .i_first     (w_first),
      .i_valid     (r_rd_valid),
      .i_counts    (i_counts),
      .i_bin_idx   (r_rd_bin),
      .o_max_count (o_peak_count),
      .o_max_bin   (o_peak_bin)
   );

`ifdef CLEAR_AFTER_READ_EN
   logic [RAM_ADDR-1:0] r_waddr;
   logic                r_wen;

   // Writing one cycle behind the read keeps port a off the address port b is reading.
   always_ff @(posedge i_clk or posedge i_res) begin
      if (i_res) begin
         r_waddr <= '0;
         r_wen   <= 1'b0;
      end else begin
         r_waddr <= r_raddr;
         r_wen   <= r_ren;
      end
   end

   assign o_waddr      = r_waddr;
   assign o_w_enable   = r_wen;
   assign o_write_flag = r_wen;
   assign o_new_counts = '0;
`else
   assign o_waddr      = '0;
   assign o_w_enable   = 1'b0;
   assign o_write_flag = 1'b0;
   assign o_new_counts = '0;
`endif

   assign o_raddr      = r_raddr;
   assign o_r_enable   = r_ren;
   assign o_read_flag  = r_ren;
   assign o_peak_valid = r_peak_valid;
   assign o_peak_pixel = r_pixel;
   assign o_busy       = (r_state != ST_IDLE);
   assign o_find_done  = r_find_done;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_his_peak_finder.sv
// Bench for his_peak_finder: RAM model, per-frame reference peaks, directed
// frames with random contents, back-pressure, busy-start and mid-scan reset.
module tb_his_peak_finder;
   import his_peak_finder_pkg::*;

   localparam int BIN    = BIN_NUM_PER_HIS_D;
   localparam int PIX    = PIXEL_NUM_PER_RAM_D;
   localparam int AW     = RAM_ADDR_D;
   localparam int PM     = PEAK_MAX_D;
   localparam int NB     = NB_D;
   localparam int PW     = his_clog2(PIX);
   localparam int W      = PW + NB + PM;
   localparam int DEPTH  = BIN * PIX;
   localparam int BUDGET = 400;

   logic          clk = 1'b0;
   logic          res = 1'b1;
   logic          start = 1'b0;
   logic          peak_ready = 1'b1;
   logic [PM-1:0] counts = '0;
   logic [AW-1:0] raddr;
   logic          r_enable;
   logic          read_flag;
   logic [AW-1:0] waddr;
   logic          w_enable;
   logic          write_flag;
   logic [PM-1:0] new_counts;
   logic          peak_valid;
   logic [PW-1:0] peak_pixel;
   logic [NB-1:0] peak_bin;
   logic [PM-1:0] peak_count;
   logic          busy;
   logic          find_done;
   state_t        dbg_state;

   logic [PM-1:0] mem [DEPTH];
   logic [PM-1:0] img [DEPTH];
   logic          load_req = 1'b0;

   int checks = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];

   always #5 clk = ~clk;

   his_peak_finder dut (
      .i_clk        (clk),
      .i_res        (res),
      .i_start      (start),
      .i_counts     (counts),
      .o_raddr      (raddr),
      .o_r_enable   (r_enable),
      .o_read_flag  (read_flag),
      .o_waddr      (waddr),
      .o_w_enable   (w_enable),
      .o_write_flag (write_flag),
      .o_new_counts (new_counts),
      .o_peak_valid (peak_valid),
      .i_peak_ready (peak_ready),
      .o_peak_pixel (peak_pixel),
      .o_peak_bin   (peak_bin),
      .o_peak_count (peak_count),
      .o_busy       (busy),
      .o_find_done  (find_done),
      .o_dbg_state  (dbg_state)
   );

   // Dual-port histogram RAM: synchronous read on port b, write on port a.
   always @(posedge clk) begin
      if (load_req) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= img[i];
      end else if (w_enable && write_flag) begin
         mem[waddr] <= new_counts;
      end
      if (r_enable) counts <= mem[raddr];
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [W-1:0] ref_peak(input int p);
      int best_b;
      int best_c;
      best_b = 0;
      best_c = int'(img[p*BIN]);
      for (int b = 1; b < BIN; b++) begin
         if (int'(img[p*BIN+b]) > best_c) begin
            best_c = int'(img[p*BIN+b]);
            best_b = b;
         end
      end
      return {PW'(p), NB'(best_b), PM'(best_c)};
   endfunction

   task automatic load_image();
      @(posedge clk); #1;
      load_req = 1'b1;
      @(posedge clk); #1;
      load_req = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ram_ports"}, {raddr, r_enable, read_flag, waddr, w_enable, write_flag, new_counts}, '0);
      chk({tag, "_result_ports"}, {peak_valid, peak_pixel, peak_bin, peak_count, busy, find_done}, '0);
      chk({tag, "_state"}, dbg_state, ST_IDLE);
   endtask

`ifdef CLEAR_AFTER_READ_EN
   task automatic chk_cleared();
      int nz;
      nz = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] != '0) nz++;
      chk("ram_cleared_nonzero_bins", nz, 0);
   endtask
`endif

   task automatic run_frame(input int stall_pix, input int stall_len,
                            input int busy_start_at, input bit chk_lat);
      int cyc, accepts, stall_left, exp_addr;
      bit done_seen, prev_valid, prev_ready, prev_ren, hs;
      logic [AW-1:0] prev_raddr;
      logic [W-1:0]  held;
      exp_q.delete();
      for (int p = 0; p < PIX; p++) exp_q.push_back(ref_peak(p));
      load_image();
      cyc = 0; accepts = 0; stall_left = stall_len; exp_addr = 0;
      done_seen = 0; prev_valid = 0; prev_ready = 1; prev_ren = 0;
      prev_raddr = '0; held = '0;
      peak_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (!done_seen && cyc < BUDGET) begin
         hs = prev_valid && prev_ready;
         if (hs) begin
            accepts++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (accepts < PIX) chk("resume_scan", {r_enable, raddr}, {1'b1, AW'(accepts*BIN)});
         end
         chk("find_done", find_done, (hs && accepts == PIX));
         done_seen = find_done || (hs && accepts == PIX);
         chk("busy", busy, 1'b1);
         chk("read_flag", read_flag, r_enable);
         if (r_enable) begin
            chk("read_addr", raddr, exp_addr[AW-1:0]);
            exp_addr++;
         end
`ifdef CLEAR_AFTER_READ_EN
         chk("wr_enable", {w_enable, write_flag}, {prev_ren, prev_ren});
         if (prev_ren) chk("wr_addr", waddr, prev_raddr);
         chk("wr_data", new_counts, '0);
         if (chk_lat && cyc == 1) chk("first_write", {w_enable, waddr}, {1'b1, AW'(0)});
`else
         chk("port_a_idle", {waddr, w_enable, write_flag, new_counts}, '0);
`endif
         if (chk_lat && cyc == 0) chk("first_read_latency", {r_enable, raddr}, {1'b1, AW'(0)});
         if (chk_lat && cyc == BIN) chk("drain_no_read", r_enable, 1'b0);
         if (peak_valid) begin
            chk("no_read_in_out", r_enable, 1'b0);
            if (!prev_valid) begin
               // Visible after edge BIN+1, so the consumer samples it on edge BIN+2.
               if (chk_lat && accepts == 0) chk("first_valid_cycle", cyc, BIN + 1);
               if (exp_q.size() > 0) chk("peak_result", {peak_pixel, peak_bin, peak_count}, exp_q[0]);
               else chk("unexpected_result", exp_q.size(), 1);
               held = {peak_pixel, peak_bin, peak_count};
            end else begin
               chk("peak_stable", {peak_pixel, peak_bin, peak_count}, held);
            end
         end
         start = (cyc == busy_start_at);
         if (peak_valid && accepts == stall_pix && stall_left > 0) begin
            peak_ready = 1'b0;
            stall_left--;
         end else begin
            peak_ready = 1'b1;
         end
         prev_valid = peak_valid;
         prev_ready = peak_ready;
         prev_ren   = r_enable;
         prev_raddr = raddr;
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      peak_ready = 1'b1;
      chk("frame_complete", done_seen, 1'b1);
      chk("read_count", exp_addr, DEPTH);
      chk("results_left", exp_q.size(), 0);
      chk("idle_after_done", {busy, dbg_state}, {1'b0, ST_IDLE});
   endtask

   initial begin
      // Clock/reset
      res = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("por");
      res = 1'b0;
      @(posedge clk); #1;
      chk_reset_outputs("idle");

      // Single peak in pixel 0, other pixels all zero
      for (int i = 0; i < DEPTH; i++) img[i] = '0;
      img[5] = PM'(37);
      run_frame(-1, 0, -1, 1'b1);
`ifdef CLEAR_AFTER_READ_EN
      chk_cleared();
`endif

      // Tie in pixel 2, max value in last bin of pixel 1, back-pressure on pixel 0
      for (int i = 0; i < DEPTH; i++) img[i] = PM'($urandom_range(0, 150));
      img[2*BIN+3]  = PM'(200);
      img[2*BIN+9]  = PM'(200);
      img[1*BIN+15] = PM'(255);
      run_frame(0, 10, -1, 1'b0);
`ifdef CLEAR_AFTER_READ_EN
      chk_cleared();
`endif

      // Full-range random with a flat pixel 3, start pulsed while busy
      for (int i = 0; i < DEPTH; i++) img[i] = PM'($urandom_range(0, 255));
      for (int b = 0; b < BIN; b++) img[3*BIN+b] = PM'(77);
      run_frame(-1, 0, 5, 1'b0);
`ifdef CLEAR_AFTER_READ_EN
      chk_cleared();
`endif

      // Reset mid-scan
      for (int i = 0; i < DEPTH; i++) img[i] = PM'($urandom_range(0, 255));
      load_image();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      chk("mid_scan_active", {busy, r_enable}, 2'b11);
      res = 1'b1;
      #1;
      chk_reset_outputs("async_reset");
      @(posedge clk); #1;
      chk_reset_outputs("held_reset");
      res = 1'b0;
      @(posedge clk); #1;
      chk("idle_after_reset", {busy, peak_valid}, 2'b00);

      // Fresh frame after reset, with stall and a busy start
      for (int i = 0; i < DEPTH; i++) img[i] = PM'($urandom_range(0, 255));
      run_frame(2, 3, 30, 1'b0);
`ifdef CLEAR_AFTER_READ_EN
      chk_cleared();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
